psram_responder: RTL and testbench
==================================

PSRAM_RESPONDER -- requirements
Module: psram_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8: internal memory is 2^ADDR_BITS bytes; only the low ADDR_BITS of the 24-bit address are used.
REQ-002 SHALL have parameter WAIT_CLKS, default 6: dummy mem_clk cycles between address and read data.
REQ-003 SHALL have clk, input, 1: system clock; at least 8x the mem_clk frequency.
REQ-004 SHALL have rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have mem_ce_n, input, 1: chip enable from initiator, active low.
REQ-006 SHALL have mem_clk, input, 1: serial clock from initiator, idle low.
REQ-007 SHALL have sio_in, input, 4: sampled state of the shared SIO bus.
REQ-008 SHALL have sio_out, output, 4: responder drive value for SIO.
REQ-009 SHALL have sio_oe, output, 1: responder drives SIO when 1.
REQ-010 SHALL have qpi_mode, output, 1: 1 = quad command mode active.
REQ-011 SHALL have busy, output, 1: 1 while mem_ce_n is low (synchronised).

Function
REQ-012 SHALL synchronise mem_ce_n, mem_clk and sio_in through 2 flops, then detect mem_clk rise and fall with one edge register; all protocol actions occur on these detected edges.
REQ-013 SHALL, on a synchronised mem_ce_n rising edge, return to IDLE: sio_oe=0, edge counter=0, partial nibble/byte discarded; qpi_mode and memory contents kept.
REQ-014 SHALL use states IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE; CE# falling moves IDLE->CMD.
REQ-015 SHALL, in SPI mode (qpi_mode=0), shift 8 bits MSB-first from sio_in[0] on rises; 0x35 sets qpi_mode=1 at the 8th rise; any other value -> IGNORE.
REQ-016 SHALL, in QPI mode, take command as 2 nibbles (high first) on rises 1-2 and address as 6 nibbles on rises 3-8, both MSB-first.
REQ-017 SHALL treat command 0xEB as quad read: after rise 8, WAIT for WAIT_CLKS rises, then RDATA.
REQ-018 SHALL, in RDATA, present a new nibble on each mem_clk fall: high nibble of mem[addr] first, then low nibble; after the low nibble, addr increments modulo 2^ADDR_BITS.
REQ-019 SHALL assert sio_oe on the fall after rise 8+WAIT_CLKS; sio_out valid no more than 3 clk after the detected fall.
REQ-020 SHALL treat command 0x38 as quad write: from rise 9, capture high then low nibble, write the byte at the low-nibble rise, increment addr modulo 2^ADDR_BITS; no wait cycles.
REQ-021 SHALL treat command 0xF5 as exit QPI: qpi_mode=0 at the 2nd rise.
REQ-022 SHALL send any other QPI command -> IGNORE; IGNORE holds sio_oe=0 until CE# rises.
REQ-023 SHALL never assert sio_oe outside RDATA.
REQ-024 SHALL give CE# rise priority when CE# rise and a mem_clk edge are detected in the same clk: the edge is ignored and no memory write occurs.
REQ-025 SHALL treat a transaction that ends after an odd number of write nibbles as discarding the half byte; memory is unchanged.

Reset
REQ-026 SHALL, while rst_n=0, force state=IDLE, sio_oe=0, sio_out=0, qpi_mode=0, busy=0 and clear the synchronisers; memory contents are undefined after power-up and not cleared.
REQ-027 SHALL, on rst_n assertion mid-transaction, abort immediately; after release, the responder ignores the remainder until CE# is seen high.

Verification
REQ-028 SHALL cover: SPI 0x35 on sio[0] -> qpi_mode=1 after the 8th rise; then QPI 0xF5 -> qpi_mode=0.
REQ-029 SHALL cover: QPI 0x38 addr 0x000000 data 0x12,0x34,0x56,0x78; then 0xEB addr 0x000000, 6 dummy clocks, 8 nibbles read -> 1,2,3,4,5,6,7,8.
REQ-030 SHALL cover: 0x38 addr 0x0000FF data 0xAA,0xBB -> mem[0xFF]=0xAA, mem[0x00]=0xBB; read at 0xFF returns 0xAA then 0xBB.
REQ-031 SHALL cover: 0x38 at 0x10 with only 1 nibble before CE# rise -> mem[0x10] unchanged; next command decodes correctly.
REQ-032 SHALL cover: unknown command 0x9F -> sio_oe stays 0 for the whole CE# low period; a following 0xEB works.
REQ-033 SHALL cover: rst_n pulsed low during RDATA -> sio_oe=0 within 1 clk, qpi_mode=0; the rest of that transaction is ignored.

Source files
------------

// File: rtl/psram_responder.sv
// Quad-SPI PSRAM target model: SPI/QPI command decode, quad read with dummy
// cycles and quad write into a 2^ADDR_BITS byte array, all sampled on clk.
module psram_responder #(
   parameter int ADDR_BITS = 8,
   parameter int WAIT_CLKS = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mem_ce_n,
   input  logic       mem_clk,
   input  logic [3:0] sio_in,
   output logic [3:0] sio_out,
   output logic       sio_oe,
   output logic       qpi_mode,
   output logic       busy,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE} state_t;

   localparam logic [7:0] CMD_QPI_EN = 8'h35;
   localparam logic [7:0] CMD_QPI_EX = 8'hF5;
   localparam logic [7:0] CMD_READ   = 8'hEB;
   localparam logic [7:0] CMD_WRITE  = 8'h38;
   localparam int DEPTH = 1 << ADDR_BITS;
   localparam int CNT_W = $clog2(WAIT_CLKS + 9) + 1;

   state_t state, state_next;

   logic [1:0] ce_sync, mclk_sync;
   logic [3:0] sio_s1, sio_s2;
   logic       ce_q, mclk_q, armed;
   logic [CNT_W-1:0] cnt;
   logic [7:0] shreg, cmd, wbuf;
   logic [23:0] addr_sh;
   logic [ADDR_BITS-1:0] addr;
   logic       half;
   logic [7:0] mem [DEPTH];

   // Synchronisers clear to 0 so CE# must be seen high after reset before a
   // falling edge can start a transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ce_sync   <= '0;
         mclk_sync <= '0;
         sio_s1    <= '0;
         sio_s2    <= '0;
         ce_q      <= 1'b0;
         mclk_q    <= 1'b0;
         armed     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         ce_sync   <= {ce_sync[0], mem_ce_n};
         mclk_sync <= {mclk_sync[0], mem_clk};
         sio_s1    <= sio_in;
         sio_s2    <= sio_s1;
         ce_q      <= ce_sync[1];
         mclk_q    <= mclk_sync[1];
         armed     <= armed | ce_sync[1];
         busy      <= ~ce_sync[1] & armed;
      end
   end

   logic ce_rise, ce_fall, rise, fall;
   logic [7:0] spi_byte, qpi_byte;
   logic [23:0] addr_next;
   logic [7:0] rd_byte;
   logic we;

   assign ce_rise   = ce_sync[1] & ~ce_q;
   assign ce_fall   = ~ce_sync[1] & ce_q;
   assign rise      = mclk_sync[1] & ~mclk_q;
   assign fall      = ~mclk_sync[1] & mclk_q;
   assign spi_byte  = {shreg[6:0], sio_s2[0]};
   assign qpi_byte  = {shreg[3:0], sio_s2};
   assign addr_next = {addr_sh[19:0], sio_s2};
   assign rd_byte   = mem[addr];
   assign we        = (state == WDATA) && rise && half && !ce_rise;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // cnt holds the number of mem_clk rises already seen in this transaction.
   always_comb begin
      state_next = state;
      if (ce_rise) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: if (ce_fall) state_next = CMD;
            CMD: begin
               if (rise) begin
                  if (!qpi_mode) begin
                     if (cnt == CNT_W'(7)) state_next = IGNORE;
                  end else if (cnt == CNT_W'(1)) begin
                     if (qpi_byte == CMD_READ || qpi_byte == CMD_WRITE) state_next = ADDR;
                     else state_next = IGNORE;
                  end
               end
            end
            ADDR: begin
               if (rise && cnt == CNT_W'(7)) begin
                  if (cmd == CMD_READ) state_next = (WAIT_CLKS == 0) ? RDATA : WAIT;
                  else state_next = WDATA;
               end
            end
            WAIT: if (rise && cnt == CNT_W'(7 + WAIT_CLKS)) state_next = RDATA;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         shreg    <= '0;
         cmd      <= '0;
         wbuf     <= '0;
         addr_sh  <= '0;
         addr     <= '0;
         half     <= 1'b0;
         sio_out  <= '0;
         sio_oe   <= 1'b0;
         qpi_mode <= 1'b0;
      end else if (ce_rise) begin
         cnt    <= '0;
         half   <= 1'b0;
         sio_oe <= 1'b0;
      end else begin
         if (state == IDLE && ce_fall) begin
            cnt  <= '0;
            half <= 1'b0;
         end
         if (rise && (state == CMD || state == ADDR || state == WAIT))
            cnt <= cnt + CNT_W'(1);
         if (state == CMD && rise) begin
            if (!qpi_mode) begin
               shreg <= spi_byte;
               if (cnt == CNT_W'(7) && spi_byte == CMD_QPI_EN) qpi_mode <= 1'b1;
            end else begin
               shreg <= qpi_byte;
               if (cnt == CNT_W'(1)) begin
                  cmd <= qpi_byte;
                  if (qpi_byte == CMD_QPI_EX) qpi_mode <= 1'b0;
               end
            end
         end
         if (state == ADDR && rise) begin
            addr_sh <= addr_next;
            if (cnt == CNT_W'(7)) addr <= addr_next[ADDR_BITS-1:0];
         end
         if (state == RDATA && fall) begin
            sio_out <= half ? rd_byte[3:0] : rd_byte[7:4];
            half    <= ~half;
            if (half) addr <= addr + ADDR_BITS'(1);
         end
         if (state == WDATA && rise) begin
            if (!half) wbuf[3:0] <= sio_s2;
            else       addr <= addr + ADDR_BITS'(1);
            half <= ~half;
         end
         if (state_next != RDATA)          sio_oe <= 1'b0;
         else if (state == RDATA && fall)  sio_oe <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= {wbuf[3:0], sio_s2};
   end

endmodule

// File: tb/tb_psram_responder.sv
// Self-checking bench for psram_responder: drives SPI/QPI transactions and
// compares reads against a byte-array memory model.
module tb_psram_responder;

   localparam int WC = 6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mem_ce_n = 1'b1;
   logic       mem_clk = 1'b0;
   logic [3:0] sio_in = 4'h0;
   logic [3:0] sio_out;
   logic       sio_oe, qpi_mode, busy;
   logic [2:0] dbg_state;

   psram_responder #(.ADDR_BITS(8), .WAIT_CLKS(WC)) dut (
      .clk(clk), .rst_n(rst_n), .mem_ce_n(mem_ce_n), .mem_clk(mem_clk),
      .sio_in(sio_in), .sio_out(sio_out), .sio_oe(sio_oe),
      .qpi_mode(qpi_mode), .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [7:0] ref_mem [0:255];
   logic       ref_qpi = 1'b0;
   logic [3:0] tx_q[$];
   logic [3:0] rx_q[$];
   logic       rx_oe_q[$];
   logic [3:0] exp_q[$];
   logic [7:0] wr_q[$];
   logic       oe_seen = 1'b0;

   always @(negedge clk) if (sio_oe === 1'b1) oe_seen = 1'b1;

   // One mem_clk period; the bus is sampled a few clk after the falling edge.
   task automatic mclk_cycle(input logic [3:0] nib);
      @(negedge clk) sio_in = nib;
      repeat (4) @(negedge clk);
      mem_clk = 1'b1;
      repeat (5) @(negedge clk);
      mem_clk = 1'b0;
      repeat (5) @(negedge clk);
      rx_q.push_back(sio_out);
      rx_oe_q.push_back(sio_oe);
   endtask

   task automatic begin_txn();
      rx_q.delete();
      rx_oe_q.delete();
      @(negedge clk) mem_ce_n = 1'b0;
      oe_seen = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic end_txn();
      @(negedge clk) mem_ce_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic run_txn(input int n);
      begin_txn();
      for (int i = 0; i < n; i++)
         mclk_cycle(i < tx_q.size() ? tx_q[i] : 4'($urandom));
      end_txn();
   endtask

   task automatic load_hdr(input logic [7:0] c, input logic [23:0] a);
      tx_q.delete();
      tx_q.push_back(c[7:4]);
      tx_q.push_back(c[3:0]);
      for (int i = 5; i >= 0; i--) tx_q.push_back(4'(a >> (4 * i)));
   endtask

   task automatic do_write(input logic [23:0] a);
      load_hdr(8'h38, a);
      foreach (wr_q[i]) begin
         tx_q.push_back(wr_q[i][7:4]);
         tx_q.push_back(wr_q[i][3:0]);
      end
      run_txn(tx_q.size());
      foreach (wr_q[i]) ref_mem[8'(a[7:0] + 8'(i))] = wr_q[i];
      checks++;
      if (oe_seen !== 1'b0) begin
         failures++;
         $display("FAIL write_oe addr=%h: sio_oe went high during write", a);
      end
   endtask

   task automatic do_read_check(input string name, input logic [23:0] a, input int nbytes);
      int first;
      logic early;
      logic [3:0] e;
      exp_q.delete();
      for (int k = 0; k < 2 * nbytes; k++) begin
         logic [7:0] b;
         b = ref_mem[8'(a[7:0] + 8'(k / 2))];
         exp_q.push_back((k % 2 == 0) ? b[7:4] : b[3:0]);
      end
      load_hdr(8'hEB, a);
      run_txn(7 + WC + 2 * nbytes);
      first = 7 + WC;
      early = 1'b0;
      for (int i = 0; i < first; i++) if (rx_oe_q[i] !== 1'b0) early = 1'b1;
      checks++;
      if (early) begin
         failures++;
         $display("FAIL %s_early_oe: sio_oe high before first data fall", name);
      end
      for (int k = 0; k < 2 * nbytes; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (rx_oe_q[first + k] !== 1'b1 || rx_q[first + k] !== e) begin
            failures++;
            $display("FAIL %s_nib%0d: got oe=%b data=%h, want oe=1 data=%h",
                     name, k, rx_oe_q[first + k], rx_q[first + k], e);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks += 4;
      if (sio_oe !== 1'b0)   begin failures++; $display("FAIL reset_oe: got %b want 0", sio_oe); end
      if (sio_out !== 4'h0)  begin failures++; $display("FAIL reset_out: got %h want 0", sio_out); end
      if (qpi_mode !== 1'b0) begin failures++; $display("FAIL reset_qpi: got %b want 0", qpi_mode); end
      if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_spi_cmd(input logic [7:0] c);
      begin_txn();
      for (int i = 7; i >= 0; i--) mclk_cycle({3'($urandom), c[i]});
      if (c == 8'h35) ref_qpi = 1'b1;
      checks += 2;
      if (qpi_mode !== ref_qpi) begin
         failures++;
         $display("FAIL spi_cmd_%h_qpi: got %b want %b", c, qpi_mode, ref_qpi);
      end
      if (busy !== 1'b1) begin failures++; $display("FAIL spi_busy: got %b want 1", busy); end
      end_txn();
   endtask

   task automatic test_qpi_exit();
      begin_txn();
      mclk_cycle(4'hF);
      mclk_cycle(4'h5);
      ref_qpi = 1'b0;
      checks++;
      if (qpi_mode !== ref_qpi) begin
         failures++;
         $display("FAIL qpi_exit: got %b want %b", qpi_mode, ref_qpi);
      end
      end_txn();
   endtask

   task automatic test_write_read();
      wr_q.delete();
      wr_q.push_back(8'h12); wr_q.push_back(8'h34);
      wr_q.push_back(8'h56); wr_q.push_back(8'h78);
      do_write(24'h000000);
      do_read_check("rd_1to8", 24'h000000, 4);
   endtask

   task automatic test_wrap();
      wr_q.delete();
      wr_q.push_back(8'hAA); wr_q.push_back(8'hBB);
      do_write(24'h0000FF);
      do_read_check("wrap_ff", 24'h0000FF, 2);
      do_read_check("wrap_00", 24'h000000, 1);
   endtask

   task automatic test_partial();
      wr_q.delete();
      wr_q.push_back(8'h5A);
      do_write(24'h000010);
      load_hdr(8'h38, 24'h000010);
      tx_q.push_back(4'hC);
      run_txn(tx_q.size());
      do_read_check("partial", 24'h000010, 1);
   endtask

   task automatic test_unknown();
      load_hdr(8'h9F, 24'h000000);
      run_txn(8 + WC + 4);
      checks++;
      if (oe_seen !== 1'b0) begin failures++; $display("FAIL unknown_oe: got 1 want 0"); end
      do_read_check("after_unknown", 24'h000001, 2);
   endtask

   task automatic test_random();
      logic [23:0] a;
      int n;
      for (int it = 0; it < 4; it++) begin
         a = {16'($urandom), 8'($urandom_range(0, 255))};
         n = $urandom_range(1, 4);
         wr_q.delete();
         for (int i = 0; i < n; i++) wr_q.push_back(8'($urandom));
         do_write(a);
         do_read_check("random", {16'($urandom), a[7:0]}, n);
      end
   endtask

   task automatic test_reset_mid();
      wr_q.delete();
      wr_q.push_back(8'hC3); wr_q.push_back(8'h3C);
      do_write(24'h000040);
      load_hdr(8'hEB, 24'h000040);
      begin_txn();
      for (int i = 0; i < 8 + WC + 1; i++) mclk_cycle(i < tx_q.size() ? tx_q[i] : 4'h0);
      checks++;
      if (sio_oe !== 1'b1) begin failures++; $display("FAIL mid_oe_before: got %b want 1", sio_oe); end
      @(negedge clk) rst_n = 1'b0;
      ref_qpi = 1'b0;
      @(posedge clk);
      #1;
      checks += 2;
      if (sio_oe !== 1'b0)   begin failures++; $display("FAIL mid_rst_oe: got %b want 0", sio_oe); end
      if (qpi_mode !== 1'b0) begin failures++; $display("FAIL mid_rst_qpi: got %b want 0", qpi_mode); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      oe_seen = 1'b0;
      for (int i = 0; i < 6; i++) mclk_cycle(4'($urandom));
      checks += 2;
      if (oe_seen !== 1'b0)  begin failures++; $display("FAIL mid_rest_oe: got 1 want 0"); end
      if (qpi_mode !== 1'b0) begin failures++; $display("FAIL mid_rest_qpi: got %b want 0", qpi_mode); end
      end_txn();
      test_spi_cmd(8'h35);
      do_read_check("after_reset", 24'h000040, 2);
   endtask

   initial begin
      test_reset();
      test_spi_cmd(8'h9F);
      test_spi_cmd(8'h35);
      test_qpi_exit();
      test_spi_cmd(8'h35);
      test_write_read();
      test_wrap();
      test_partial();
      test_unknown();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
